// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the packet-locking mux arbiter.
// Imported by the arbiter top and its round-robin picker.
package mux_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_N       = 8;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/mux_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester scanning
// upward (with wrap) from the one after the last grant.
module rr_picker
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDW-1:0]     i_last_grant,
  output logic               o_any,
  output logic [IDW-1:0]     o_winner
);

  int w_idx;

  // Scan farthest-first so the nearest valid requester is assigned last.
  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(i_last_grant) + k) % NUM_REQ;
      if (i_valid[w_idx]) begin
        o_any    = 1'b1;
        o_winner = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin N-way mux arbiter that locks onto a requester until the
// last beat of its packet, feeding a single registered output stage.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [N-1:0]         out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_last,
  input  logic                 out_ready
);

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_lock_id;
  logic [IDW-1:0]   r_last_grant;
  logic             r_out_valid;
  logic [N-1:0]     r_out_data;
  logic [IDW-1:0]   r_out_id;
  logic             r_out_last;

  logic             w_load_en;
  logic             w_any;
  logic [IDW-1:0]   w_winner;
  logic             w_sel_valid;
  logic [IDW-1:0]   w_sel_id;
  logic             w_accept;
  logic [N-1:0]     w_sel_data;
  logic             w_sel_last;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .i_valid      (req_valid),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  assign w_load_en   = !r_out_valid || out_ready;
  assign w_sel_valid = (r_state == LOCKED) ? req_valid[r_lock_id] : w_any;
  assign w_sel_id    = (r_state == LOCKED) ? r_lock_id : w_winner;
  assign w_accept    = w_load_en && w_sel_valid && !reset;
  assign w_sel_data  = req_data[int'(w_sel_id)*N +: N];
  assign w_sel_last  = req_last[w_sel_id];

  // Grant strobe: one-hot on the accepted requester, zero otherwise.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready = NUM_REQ'(1) << w_sel_id;
  end

  // Packet lock: enter on a non-last first beat, leave on the last beat.
  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      unique case (r_state)
        IDLE:    if (!w_sel_last) w_next = LOCKED;
        LOCKED:  if (w_sel_last) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // State, lock owner and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lock_id    <= '0;
      r_last_grant <= IDW'(NUM_REQ-1);
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last_grant <= w_sel_id;
        if (r_state == IDLE && !w_sel_last) r_lock_id <= w_sel_id;
      end
    end
  end

  // Output register: load on accept, drain when consumed with nothing new.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_id    <= w_sel_id;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (N=8, NUM_REQ=4).
// Inputs change on negedge; outputs sampled #1 after edges.
module tb_mux_arbiter;

  localparam int N  = 8;
  localparam int NR = 4;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*N-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic [1:0]    out_id;
  logic          out_last;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'hDDCCBBAA;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_id, out_last} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%0d l=%b want 0",
               out_valid, out_data, out_id, out_last);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data[2*N +: N] = 8'hA5;
    req_last  = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 ||
        out_id !== 2'd2 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h id=%0d l=%b want 1 a5 2 1",
               out_valid, out_data, out_id, out_last);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_id;
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      exp_id = 2'(k % 4);
      checks++;
      if (out_valid !== 1'b1 || out_id !== exp_id ||
          out_data !== (8'h10 + 8'(exp_id))) begin
        errors++;
        $display("FAIL fair_%0d: got v=%b id=%0d d=%h want 1 %0d %h",
                 k, out_valid, out_id, out_data, exp_id,
                 8'h10 + 8'(exp_id));
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp_d;
    do_reset();
    req_valid = 4'b1010;
    req_data[3*N +: N] = 8'h33;
    req_last[3] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      exp_d = 8'h11 + 8'(b);
      req_data[1*N +: N] = exp_d;
      req_last[1] = (b == 2);
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
        errors++;
        $display("FAIL lock_ready_%0d: got %b want 0010", b, req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_id !== 2'd1 || out_data !== exp_d ||
          out_last !== (b == 2)) begin
        errors++;
        $display("FAIL lock_beat_%0d: got id=%0d d=%h l=%b want 1 %h %b",
                 b, out_id, out_data, out_last, exp_d, (b == 2));
      end
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL lock_after_ready: got %b want 1000", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_id !== 2'd3 || out_data !== 8'h33) begin
      errors++;
      $display("FAIL lock_after: got id=%0d d=%h want 3 33",
               out_id, out_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001;
    req_data[0 +: N] = 8'h41;
    req_last  = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    req_data[0 +: N] = 8'h42;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready_%0d: got %b want 0000", c, req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h41 ||
          out_id !== 2'd0 || out_last !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h id=%0d l=%b want 1 41 0 1",
                 c, out_valid, out_data, out_id, out_last);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 0001", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h42) begin
      errors++;
      $display("FAIL bp_release_out: got v=%b d=%h want 1 42",
               out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100;
    req_data[2*N +: N] = 8'h21;
    req_last  = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    req_data[2*N +: N] = 8'h22;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_clear: got v=%b rdy=%b want 0 0000",
               out_valid, req_ready);
    end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'h44332211;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ready: got %b want 0001", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL midrst_first: got v=%b id=%0d d=%h want 1 0 11",
               out_valid, out_id, out_data);
    end
  endtask

  task automatic test_idle_drain();
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_data[0 +: N] = 8'h5A;
    req_last  = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: got %b want 0", out_valid);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL drain_idle: got %b want 0010", req_ready);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_backpressure();
    test_reset_mid();
    test_idle_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: N, 8, data width of each requester's beat.
REQ-002 Parameter: NUM_REQ, 4, number of requesters; legal range 2..16.
REQ-003 Derived constant: IDW = $clog2(NUM_REQ), requester-ID width.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 Port: req_data  input  NUM_REQ*N  packed beats; requester i occupies bits [i*N +: N].
REQ-008 Port: req_last  input  NUM_REQ  per-requester last-beat-of-packet flag.
REQ-009 Port: req_ready  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-010 Port: out_valid  output  1  output register holds a beat.
REQ-011 Port: out_data  output  N  selected beat.
REQ-012 Port: out_id  output  IDW  index of the requester that supplied out_data.
REQ-013 Port: out_last  output  1  copy of req_last for the held beat.
REQ-014 Port: out_ready  input  1  downstream consumes the held beat.

Function
REQ-015 load_en = !out_valid || out_ready; a beat is accepted only in a cycle with load_en = 1.
REQ-016 FSM states: IDLE, LOCKED; lock_id register (IDW bits) names the owner while LOCKED.
REQ-017 IDLE, load_en = 1, any req_valid: winner = first valid requester scanning upward, with wrap, from (last_grant+1) mod NUM_REQ.
REQ-018 Accepting a beat asserts req_ready[winner] combinationally in that cycle; every other req_ready bit is 0.
REQ-019 On acceptance: out_data/out_id/out_last load the winner's beat, out_valid <= 1, last_grant <= winner.
REQ-020 IDLE acceptance with req_last = 0: next state LOCKED, lock_id <= winner; with req_last = 1: remain IDLE.
REQ-021 LOCKED: only lock_id is eligible; other requesters' req_valid is ignored and their req_ready is 0.
REQ-022 LOCKED, load_en = 1, req_valid[lock_id] = 1: accept the beat; accepted beat with req_last = 1 returns the FSM to IDLE.
REQ-023 No acceptance while load_en = 1: out_valid <= 0 in the next cycle if out_ready = 1, else the register holds.
REQ-024 While out_valid = 1 and out_ready = 0: out_data, out_id, out_last hold stable; all req_ready are 0.
REQ-025 Throughput: one beat per cycle while out_ready stays 1 and the eligible requester stays valid; latency from acceptance to out_valid is 1 cycle.
REQ-026 req_ready never asserts for a requester whose req_valid is 0.
REQ-027 Priority pointer wraps: with last_grant = NUM_REQ-1, requester 0 is checked first.

Reset
REQ-028 While reset = 1: state = IDLE, out_valid = 0, out_data = 0, out_id = 0, out_last = 0, lock_id = 0, last_grant = NUM_REQ-1, req_ready = 0.
REQ-029 Reset asserted mid-packet discards the held beat and the lock; after release, the first arbitration gives priority to requester 0.

Structure
REQ-030 Shared package mux_arb_pkg holds the state enum typedef (IDLE, LOCKED) and the default N/NUM_REQ constants.
REQ-031 Combinational round-robin selection is a sub-module rr_picker with inputs (valid vector, last_grant) and outputs (any, winner index).
REQ-032 Data selection into the output register is an indexed select on req_data by the winner or lock_id; no other storage.

Verification
REQ-033 Single beat: req_valid = 4'b0100, req_data[2] = 8'hA5, req_last[2] = 1, out_ready = 1 -> req_ready = 4'b0100 in the same cycle; next cycle out_valid = 1, out_data = 8'hA5, out_id = 2, out_last = 1.
REQ-034 Fairness: all four valid, single-beat packets, out_ready = 1 -> out_id sequence 0,1,2,3,0.
REQ-035 Lock: requester 1 sends 3 beats (last on the 3rd) while requester 3 is continuously valid -> out_id = 1,1,1, then 3; req_ready[3] = 0 during the lock.
REQ-036 Backpressure: out_ready = 0 for 5 cycles with out_valid = 1 -> outputs are unchanged, req_ready = 0; on release one beat is consumed and the next beat is accepted in the same cycle.
REQ-037 Reset mid-packet: reset pulsed while LOCKED on requester 2 -> out_valid = 0; after release with all valid, the first out_id = 0.
REQ-038 Idle drain: the last beat is consumed with no req_valid -> out_valid = 0 in the next cycle and the FSM is IDLE.
